mem_stage: RTL and testbench
============================

# mem_stage

Memory-access stage of the five-stage RV32 pipeline: the receiving end of the execute-to-memory bus. It accepts one instruction at a time from execute under a valid/ready handshake and issues a single word read or write to the data RAM over a req/ack interface. It resolves taken branches, then presents write-back data to the write-back stage under a second valid/ready handshake.

## Interface
- `ES2MS_W`, default 107: width of the incoming execute bus.
- `MS2WS_W`, default 38: width of the outgoing write-back bus.
- `clk`, input, 1: clock.
- `rst_n`, input, 1: reset, asynchronous, active-low.
- `es_valid`, input, 1: execute presents a valid instruction on `es2ms_bus`.
- `es2ms_bus`, input, 107: fields are:
  - [106:75] branch target
  - [74:43] ALU result
  - [42:11] store data
  - [10:6] rd
  - [5:1] ctrl {branch, mem_read, mem_write, mem2reg, reg_write}
  - [0] zero
- `ms_ready`, output, 1: stage accepts `es2ms_bus` this cycle.
- `ms_valid`, output, 1: `ms2ws_bus` holds a completed instruction.
- `ws_ready`, input, 1: write-back accepts `ms2ws_bus` this cycle.
- `ms2ws_bus`, output, 38: fields are [37] reg_write, [36:32] rd, [31:0] wb_data.
- `dram_req`, output, 1: data RAM request.
- `dram_we`, output, 1: 1 for write, 0 for read.
- `dram_addr`, output, 32: word address, {alu_result[31:2], 2'b00}.
- `dram_wdata`, output, 32: store data.
- `dram_ack`, input, 1: request completed this cycle; read data is valid with it.
- `dram_rdata`, input, 32: read data.
- `br_taken`, output, 1: branch redirect pulse.
- `br_target`, output, 32: redirect PC.

## Operation
- States are EMPTY, ISSUE and HOLD. Reset state is EMPTY.
- `ms_ready` = (state==EMPTY) || (state==HOLD && ws_ready). The value is combinational.
- Accept happens on `es_valid && ms_ready`. On accept, the bus is latched into internal register `es_r`.
  - If mem_read or mem_write is set, next state is ISSUE.
  - Otherwise next state is HOLD, with `ms2ws_bus` <= {reg_write, rd, alu_result}.
- ISSUE:
  - `dram_req`=1. `dram_we` = mem_write && !mem_read.
  - `dram_addr` and `dram_wdata` come from `es_r` and are stable for the whole request.
  - On `dram_ack`, go to HOLD and set wb_data = mem2reg ? `dram_rdata` : alu_result.
- HOLD: `ms_valid`=1.
  - If `ws_ready`, hand off, then apply the accept rule (back-to-back) or go to EMPTY.
  - If `ws_ready` is low, `ms2ws_bus` is held unchanged.
- `br_taken` = HOLD && `ws_ready` && branch && zero. It is one cycle per branch instruction. `br_target` = `es_r` target.
- When mem_read and mem_write are both set, the read wins and no write is issued.
- `dram_ack` outside ISSUE is ignored.
- A store with mem2reg=0 writes back alu_result. When reg_write=0, write-back discards the data.

## Timing
- Reset values of outputs:
  - `ms_valid`, `dram_req`, `dram_we`, `br_taken` = 0.
  - `ms2ws_bus` = 0.
  - `dram_addr`, `dram_wdata`, `br_target` = 0 (since `es_r` = 0).
  - `ms_ready` = 1.
- ALU-only instruction: accepted at edge t, `ms_valid` from t+1.
- Memory instruction:
  - Accepted at t. `dram_req` rises at t+1.
  - If ack is in the same cycle, `ms_valid` from t+2.
  - Each wait cycle adds one.
- Throughput is 1 instruction/cycle for ALU-only streams with `ws_ready`=1.
- Handoff and accept in the same cycle are legal. There are no bubbles.
- `dram_req` drops the cycle after ack. A new request needs a fresh ISSUE entry, so the minimum is 1 idle cycle between back-to-back requests.
- Async reset mid-ISSUE: `dram_req` drops immediately and the in-flight instruction is discarded. The RAM must tolerate an abandoned request.
- `ws_ready` low in HOLD stalls indefinitely. Meanwhile `ms_ready`=0, and execute must hold `es_valid` and `es2ms_bus`.

## Structure
- Shared package `pipe_bus_pkg` holds:
  - bus widths
  - field offsets of `es2ms_bus` and `ms2ws_bus`
  - ctrl bit indices
  - the state encoding (EMPTY=2'd0, ISSUE=2'd1, HOLD=2'd2)
- The whole block is one module. The FSM and wb mux are inline; no sub-module is warranted.
- Optional split: `dram_if_fsm`, if a second master is ever added.

## Test plan
- ALU-only, result 0x0000_1234, rd=5, reg_write=1, `ws_ready`=1 -> `ms_valid` at t+1 with `ms2ws_bus`={1,5,0x1234}; `ms_ready` stays 1.
- Load from addr 0x0000_0104, `dram_ack` after 3 cycles returning 0xDEADBEEF -> `dram_addr`=0x104 and `dram_we`=0 held 3 cycles; wb_data=0xDEADBEEF; `ms_ready`=0 throughout.
- Store of 0xCAFEF00D to 0x200 with zero-wait ack -> a single-cycle `dram_req` with `dram_we`=1 and `dram_wdata`=0xCAFEF00D; `ms_valid` at t+2.
- Branch with zero=1, target 0x80, `ws_ready` low for 2 cycles -> `br_taken` pulses once, in the handoff cycle, with `br_target`=0x80; with zero=0 there is no pulse.
- Back-to-back ALU, load, ALU with random `ws_ready` -> in-order outputs with none dropped or duplicated, and `ms2ws_bus` stable while stalled.
- `rst_n` asserted mid-ISSUE -> `dram_req`=0 asynchronously, state EMPTY, `ms_valid`=0; a late `dram_ack` after reset is ignored.

Source files
------------

// File: rtl/pipe_bus_pkg.sv
// Shared execute->memory->write-back bus layout and memory-stage state encoding.
package pipe_bus_pkg;

  localparam int unsigned ES2MS_BUS_W = 107;
  localparam int unsigned MS2WS_BUS_W = 38;

  // es2ms_bus field LSB positions
  localparam int unsigned ES_TGT_LSB  = 75;
  localparam int unsigned ES_ALU_LSB  = 43;
  localparam int unsigned ES_SD_LSB   = 11;
  localparam int unsigned ES_RD_LSB   = 6;
  localparam int unsigned ES_CTRL_LSB = 1;
  localparam int unsigned ES_ZERO_BIT = 0;

  // bit indices inside the 5-bit ctrl field
  localparam int unsigned CTRL_BRANCH    = 4;
  localparam int unsigned CTRL_MEM_READ  = 3;
  localparam int unsigned CTRL_MEM_WRITE = 2;
  localparam int unsigned CTRL_MEM2REG   = 1;
  localparam int unsigned CTRL_REG_WRITE = 0;

  // ms2ws_bus field positions
  localparam int unsigned WS_RW_BIT = 37;
  localparam int unsigned WS_RD_LSB = 32;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ISSUE = 2'd1,
    HOLD  = 2'd2
  } ms_state_e;

endpackage

// File: rtl/mem_stage.sv
// RV32 memory-access stage: accepts from execute, performs one data-RAM
// access over req/ack, resolves taken branches, hands results to write-back.
module mem_stage
  import pipe_bus_pkg::*;
#(
  parameter int unsigned ES2MS_W = ES2MS_BUS_W,
  parameter int unsigned MS2WS_W = MS2WS_BUS_W
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               es_valid,
  input  logic [ES2MS_W-1:0] es2ms_bus,
  output logic               ms_ready,
  output logic               ms_valid,
  input  logic               ws_ready,
  output logic [MS2WS_W-1:0] ms2ws_bus,
  output logic               dram_req,
  output logic               dram_we,
  output logic [31:0]        dram_addr,
  output logic [31:0]        dram_wdata,
  input  logic               dram_ack,
  input  logic [31:0]        dram_rdata,
  output logic               br_taken,
  output logic [31:0]        br_target
);

  ms_state_e          state, state_nx;
  logic [ES2MS_W-1:0] es_r;
  logic [MS2WS_W-1:0] ms2ws_r, ms2ws_nx;
  logic               accept;

  logic [31:0] r_tgt, r_alu, r_sd;
  logic [4:0]  r_rd;
  logic [4:0]  r_ctrl;
  logic        r_zero;
  logic [4:0]  in_ctrl;

  assign r_tgt   = es_r[ES_TGT_LSB +: 32];
  assign r_alu   = es_r[ES_ALU_LSB +: 32];
  assign r_sd    = es_r[ES_SD_LSB +: 32];
  assign r_rd    = es_r[ES_RD_LSB +: 5];
  assign r_ctrl  = es_r[ES_CTRL_LSB +: 5];
  assign r_zero  = es_r[ES_ZERO_BIT];
  assign in_ctrl = es2ms_bus[ES_CTRL_LSB +: 5];

  always_comb begin
    state_nx = state;
    ms2ws_nx = ms2ws_r;
    ms_ready = (state == EMPTY) || ((state == HOLD) && ws_ready);
    accept   = es_valid && ms_ready;

    case (state)
      ISSUE: begin
        if (dram_ack) begin
          state_nx = HOLD;
          ms2ws_nx = {r_ctrl[CTRL_REG_WRITE], r_rd,
                      r_ctrl[CTRL_MEM2REG] ? dram_rdata : r_alu};
        end
      end
      HOLD: begin
        if (ws_ready) state_nx = EMPTY;
      end
      default: ;
    endcase

    // A HOLD handoff and a new accept may share the same edge; accept overrides.
    if (accept) begin
      if (in_ctrl[CTRL_MEM_READ] || in_ctrl[CTRL_MEM_WRITE]) begin
        state_nx = ISSUE;
      end else begin
        state_nx = HOLD;
        ms2ws_nx = {in_ctrl[CTRL_REG_WRITE], es2ms_bus[ES_RD_LSB +: 5],
                    es2ms_bus[ES_ALU_LSB +: 32]};
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= EMPTY;
      es_r    <= '0;
      ms2ws_r <= '0;
    end else begin
      state   <= state_nx;
      ms2ws_r <= ms2ws_nx;
      if (accept) es_r <= es2ms_bus;
    end
  end

  assign ms_valid   = (state == HOLD);
  assign ms2ws_bus  = ms2ws_r;
  assign dram_req   = (state == ISSUE);
  // Read wins when both read and write are flagged.
  assign dram_we    = dram_req && r_ctrl[CTRL_MEM_WRITE] && !r_ctrl[CTRL_MEM_READ];
  assign dram_addr  = {r_alu[31:2], 2'b00};
  assign dram_wdata = r_sd;
  assign br_taken   = (state == HOLD) && ws_ready && r_ctrl[CTRL_BRANCH] && r_zero;
  assign br_target  = r_tgt;

endmodule

// File: tb/tb_mem_stage.sv
// Scoreboard bench for mem_stage: reference model predicts write-back and
// data-RAM traffic per instruction; monitors compare as the DUT presents them.
module tb_mem_stage;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         es_valid;
  logic [106:0] es2ms_bus;
  logic         ms_ready, ms_valid, ws_ready;
  logic [37:0]  ms2ws_bus;
  logic         dram_req, dram_we, dram_ack;
  logic [31:0]  dram_addr, dram_wdata, dram_rdata;
  logic         br_taken;
  logic [31:0]  br_target;

  always #5 clk = ~clk;

  mem_stage #(.ES2MS_W(107), .MS2WS_W(38)) dut (
    .clk(clk), .rst_n(rst_n),
    .es_valid(es_valid), .es2ms_bus(es2ms_bus), .ms_ready(ms_ready),
    .ms_valid(ms_valid), .ws_ready(ws_ready), .ms2ws_bus(ms2ws_bus),
    .dram_req(dram_req), .dram_we(dram_we), .dram_addr(dram_addr),
    .dram_wdata(dram_wdata), .dram_ack(dram_ack), .dram_rdata(dram_rdata),
    .br_taken(br_taken), .br_target(br_target)
  );

  int cmp_cnt = 0;
  int err_cnt = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    cmp_cnt++;
    if (act !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  typedef struct {logic [37:0] bus; logic br; logic [31:0] tgt;} wb_exp_t;
  typedef struct {logic we; logic [31:0] addr; logic [31:0] wdata;} req_exp_t;

  wb_exp_t     sb_q[$];
  req_exp_t    rq_q[$];
  logic [31:0] ram_mem[logic [31:0]];
  logic [31:0] model_mem[logic [31:0]];

  int ram_wait = -1;
  bit stray_en = 1'b0;
  bit ram_auto = 1'b1;
  int ws_mode  = 0;
  int n_br     = 0;

  function automatic logic [31:0] dflt(input logic [31:0] a);
    return a ^ 32'h5A5A_C3C3;
  endfunction

  // write-back readiness: 0 always ready, 1 random, 2 stalled
  initial begin
    ws_ready = 1'b1;
    forever begin
      @(posedge clk);
      #2;
      case (ws_mode)
        0:       ws_ready = 1'b1;
        1:       ws_ready = 1'($urandom_range(0, 1));
        default: ws_ready = 1'b0;
      endcase
    end
  end

  // data RAM: checks each new request against the model, answers after a wait
  initial begin
    bit       busy;
    int       cnt;
    req_exp_t cur, e;
    busy = 1'b0; cnt = 0;
    dram_ack = 1'b0; dram_rdata = '0;
    forever begin
      @(negedge clk);
      if (!ram_auto) continue;
      dram_ack = 1'b0;
      dram_rdata = $urandom;
      if (!rst_n) begin
        busy = 1'b0;
        continue;
      end
      if (dram_req) begin
        if (!busy) begin
          busy = 1'b1;
          cnt = (ram_wait < 0) ? $urandom_range(0, 3) : ram_wait;
          cur.we = dram_we; cur.addr = dram_addr; cur.wdata = dram_wdata;
          if (rq_q.size() == 0) chk("dram_unexpected_req", 1, 0);
          else begin
            e = rq_q.pop_front();
            chk("dram_we", cur.we, e.we);
            chk("dram_addr", cur.addr, e.addr);
            chk("dram_wdata", cur.wdata, e.wdata);
          end
        end else begin
          chk("dram_stable", {dram_we, dram_addr, dram_wdata}, {cur.we, cur.addr, cur.wdata});
        end
        if (cnt == 0) begin
          dram_ack = 1'b1;
          busy = 1'b0;
          if (cur.we) ram_mem[cur.addr] = cur.wdata;
          else dram_rdata = ram_mem.exists(cur.addr) ? ram_mem[cur.addr] : dflt(cur.addr);
        end else cnt--;
      end else begin
        busy = 1'b0;
        if (stray_en) dram_ack = ($urandom_range(0, 3) == 0);
      end
    end
  end

  // write-back monitor
  initial begin
    logic        stalled;
    logic [37:0] held;
    wb_exp_t     e;
    stalled = 1'b0; held = '0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        stalled = 1'b0;
        continue;
      end
      if (stalled) chk("hold_stable", {ms_valid, ms2ws_bus}, {1'b1, held});
      if (ms_valid && ws_ready) begin
        if (sb_q.size() == 0) chk("unexpected_output", 1, 0);
        else begin
          e = sb_q.pop_front();
          chk("wb_bus", ms2ws_bus, e.bus);
          chk("br_taken", br_taken, e.br);
          if (e.br) chk("br_target", br_target, e.tgt);
        end
      end else if (br_taken) chk("br_outside_handoff", br_taken, 0);
      if (br_taken) n_br++;
      stalled = ms_valid && !ws_ready;
      held = ms2ws_bus;
    end
  end

  // Called at posedge+1; returns at posedge+1 after the accepting edge.
  task automatic issue(input logic [31:0] tgt, input logic [31:0] alu, input logic [31:0] sd,
                       input logic [4:0] rd, input logic br, input logic mr, input logic mw,
                       input logic m2r, input logic rw, input logic z, output int waits);
    wb_exp_t      e;
    req_exp_t     r;
    logic [31:0]  a;
    logic [127:0] junk;
    bit           acc;
    a = {alu[31:2], 2'b00};
    e.bus = {rw, rd, alu};
    if (mr) begin
      if (m2r) e.bus[31:0] = model_mem.exists(a) ? model_mem[a] : dflt(a);
    end else if (mw) model_mem[a] = sd;
    e.br = br && z;
    e.tgt = tgt;
    if (mr || mw) begin
      r.we = mw && !mr; r.addr = a; r.wdata = sd;
      rq_q.push_back(r);
    end
    sb_q.push_back(e);
    es2ms_bus = {tgt, alu, sd, rd, br, mr, mw, m2r, rw, z};
    es_valid = 1'b1;
    waits = 0;
    forever begin
      @(negedge clk);
      acc = ms_ready;
      @(posedge clk);
      if (acc) break;
      waits++;
      if (waits > 500) begin
        chk("accept_timeout", 1, 0);
        break;
      end
    end
    #1;
    es_valid = 1'b0;
    junk = {$urandom, $urandom, $urandom, $urandom};
    es2ms_bus = junk[106:0];
  endtask

  task automatic rand_instr();
    int          k;
    int          w;
    logic        mr, mw, m2r;
    logic [31:0] alu;
    k = $urandom_range(0, 4);
    mr = 1'b0; mw = 1'b0; m2r = 1'($urandom_range(0, 1));
    case (k)
      1: mr = 1'b1;
      2: begin mw = 1'b1; m2r = 1'b0; end
      3: begin mr = 1'b1; mw = 1'b1; end
      default: ;
    endcase
    alu = (mr || mw) ? 32'($urandom_range(0, 31)) : $urandom;
    issue($urandom, alu, $urandom, 5'($urandom), 1'($urandom_range(0, 1)),
          mr, mw, m2r, 1'($urandom), 1'($urandom), w);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int w, c, rq, rdy, sum, br0;
    rst_n = 1'b0;
    es_valid = 1'b0;
    es2ms_bus = '0;
    #3;
    chk("rst_ms_valid", ms_valid, 0);
    chk("rst_dram_req", dram_req, 0);
    chk("rst_dram_we", dram_we, 0);
    chk("rst_br_taken", br_taken, 0);
    chk("rst_ms2ws_bus", ms2ws_bus, 0);
    chk("rst_dram_addr", dram_addr, 0);
    chk("rst_dram_wdata", dram_wdata, 0);
    chk("rst_br_target", br_target, 0);
    chk("rst_ms_ready", ms_ready, 1);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;

    // ALU-only: valid one cycle after accept
    issue(32'h0, 32'h0000_1234, 32'h0, 5'd5, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, w);
    c = 0;
    do begin @(negedge clk); c++; end while (!ms_valid && c < 100);
    chk("alu_latency", c, 1);
    chk("alu_ms_ready", ms_ready, 1);
    @(posedge clk); #1;

    // load with two wait cycles (request held three cycles)
    ram_mem[32'h104] = 32'hDEADBEEF;
    model_mem[32'h104] = 32'hDEADBEEF;
    ram_wait = 2;
    issue(32'h0, 32'h0000_0106, 32'h0, 5'd7, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, w);
    c = 0; rq = 0; rdy = 0;
    do begin
      @(negedge clk); c++;
      if (dram_req) begin rq++; if (ms_ready) rdy++; end
    end while (!ms_valid && c < 100);
    chk("load_req_cycles", rq, 3);
    chk("load_ms_ready_high", rdy, 0);
    chk("load_latency", c, 4);
    @(posedge clk); #1;

    // zero-wait store
    ram_wait = 0;
    issue(32'h0, 32'h0000_0200, 32'hCAFEF00D, 5'd3, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, w);
    c = 0; rq = 0;
    do begin @(negedge clk); c++; if (dram_req) rq++; end while (!ms_valid && c < 100);
    chk("store_req_cycles", rq, 1);
    chk("store_latency", c, 2);
    chk("store_ram", ram_mem[32'h200], 32'hCAFEF00D);
    @(posedge clk); #1;

    // taken branch stalled two cycles by write-back, then not-taken branch
    br0 = n_br;
    ws_mode = 2;
    issue(32'h0000_0080, $urandom, $urandom, 5'd1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, w);
    repeat (2) @(posedge clk);
    #1 ws_mode = 0;
    repeat (3) @(posedge clk);
    #1 chk("br_pulse_count", n_br - br0, 1);
    br0 = n_br;
    issue(32'h0000_0080, $urandom, $urandom, 5'd1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, w);
    repeat (3) @(posedge clk);
    #1 chk("br_not_taken_count", n_br - br0, 0);

    // ALU stream with write-back always ready: one per cycle
    sum = 0;
    for (int i = 0; i < 6; i++) begin
      issue($urandom, $urandom, $urandom, 5'($urandom), 1'b0, 1'b0, 1'b0,
            1'($urandom), 1'($urandom), 1'($urandom), w);
      sum += w;
    end
    chk("alu_throughput_waits", sum, 0);

    // random mix with random write-back stalls and stray acks
    ws_mode = 1;
    ram_wait = -1;
    stray_en = 1'b1;
    for (int i = 0; i < 200; i++) rand_instr();
    ws_mode = 0;
    for (int i = 0; i < 400 && sb_q.size() != 0; i++) @(posedge clk);
    #1;
    stray_en = 1'b0;
    chk("drain_wb_queue", sb_q.size(), 0);
    chk("drain_req_queue", rq_q.size(), 0);

    // async reset during a pending load, then a late ack
    @(posedge clk); #1;
    ram_wait = 20;
    issue(32'h0, 32'h0000_0040, 32'h0, 5'd9, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, w);
    repeat (3) @(negedge clk);
    chk("pre_reset_req", dram_req, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("reset_req_drop", dram_req, 0);
    chk("reset_ms_valid", ms_valid, 0);
    chk("reset_ms_ready", ms_ready, 1);
    sb_q.delete();
    rq_q.delete();
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    ram_auto = 1'b0;
    @(negedge clk);
    dram_ack = 1'b1;
    dram_rdata = 32'h1111_2222;
    @(negedge clk);
    dram_ack = 1'b0;
    chk("late_ack_req", dram_req, 0);
    chk("late_ack_valid", ms_valid, 0);
    ram_auto = 1'b1;
    ram_wait = 0;
    @(posedge clk); #1;
    issue(32'h0, 32'h0000_ABCD, 32'h0, 5'd4, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, w);
    repeat (3) @(posedge clk);
    #1 chk("post_reset_drain", sb_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, err_cnt);
    $finish;
  end

endmodule
